// File: rtl/hamming_secded_enc_stream.sv
// -----------------------------------------------------------------------------
// hamming_secded_enc_stream
//   Streaming Hamming / extended-Hamming (SECDED) encoder with valid/ready on
//   both sides. It has a two-entry output buffer (a main output register plus a
//   skid register), so it can move one word per cycle. A per-word error mask is
//   XORed onto the codeword so that decoders can be tested. A wrapping counter
//   counts the words that leave the block.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active high
//   in_valid   in   1       data_in / inj_mask are valid
//   in_ready   out  1       a word can be accepted this cycle
//   data_in    in   DATA_W  data word, bit0 = D1
//   inj_mask   in   CODE_W  XORed onto the encoded word, captured with data_in
//   out_valid  out  1       data_out holds a codeword
//   out_ready  in   1       downstream accepts data_out
//   data_out   out  CODE_W  registered codeword (Hamming position i at bit i-1)
//   word_cnt   out  CNT_W   number of output handshakes, wraps
// -----------------------------------------------------------------------------
module hamming_secded_enc_stream #(
   parameter int  DATA_W = 4,
   parameter int  SECDED = 1,
   parameter int  CNT_W  = 16,
   // Smallest r with 2**r >= DATA_W + r + 1, for DATA_W in 1..120
   localparam int PAR_W  = (DATA_W <= 1)  ? 2 :
                           (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 :
                           (DATA_W <= 57) ? 6 : 7,
   localparam int CODE_W = DATA_W + PAR_W + SECDED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CODE_W-1:0] inj_mask,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] data_out,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int HAM_W = DATA_W + PAR_W;

   // Data bits fill the non-power-of-two positions in ascending order. Each
   // parity position 2**k then takes even parity over every position whose
   // index has bit k set. Parity slots are still zero when that parity is
   // summed, so including them has no effect.
   function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] cw;
      logic              par;
      int                di;
      cw = '0;
      di = 0;
      for (int p = 1; p <= HAM_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[di];
            di++;
         end else begin
            cw[p-1] = 1'b0;
         end
      end
      for (int k = 0; k < PAR_W; k++) begin
         par = 1'b0;
         for (int p = 1; p <= HAM_W; p++) begin
            if (((p >> k) & 1) != 0) begin
               par = par ^ cw[p-1];
            end else begin
               par = par;
            end
         end
         cw[(1 << k) - 1] = par;
      end
      // The overall bit covers the clean codeword; the mask is applied later
      if (SECDED != 0) begin
         cw[CODE_W-1] = ^cw[HAM_W-1:0];
      end else begin
         cw = cw;
      end
      return cw;
   endfunction

   logic [CODE_W-1:0] main_q, main_d;
   logic              main_vld_q, main_vld_d;
   logic [CODE_W-1:0] skid_q, skid_d;
   logic              skid_vld_q, skid_vld_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [CODE_W-1:0] enc_s;
   logic              accept_s;
   logic              drain_s;

   assign enc_s    = encode(data_in) ^ inj_mask;
   // A full skid register is the only reason to refuse a word
   assign in_ready = ~skid_vld_q & ~rst;
   assign accept_s = in_valid & in_ready;
   assign drain_s  = main_vld_q & out_ready;

   // Next state for the main/skid buffer and the word counter
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      cnt_d      = cnt_q;
      if (drain_s) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (skid_vld_q) begin
            // in_ready is low here, so no word can arrive on this edge
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (accept_s) begin
            main_d = enc_s;
         end else begin
            main_vld_d = 1'b0;
         end
      end else begin
         if (accept_s && main_vld_q) begin
            skid_d     = enc_s;
            skid_vld_d = 1'b1;
         end else if (accept_s) begin
            main_d     = enc_s;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = main_vld_q;
         end
      end
   end

   // Buffer and counter registers; reset discards buffered words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         main_q     <= main_d;
         main_vld_q <= main_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid = main_vld_q;
   assign data_out  = main_q;
   assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_hamming_secded_enc_stream.sv
module tb_hamming_secded_enc_stream;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid  [3];
   logic [127:0] din       [3];
   logic [127:0] msk       [3];
   logic         out_ready [3];
   int           mode      [3];   // 0: out_ready low, 1: high, 2: random

   int checks = 0;
   int errors = 0;

   logic [127:0] sbq  [3][$];
   int           synq [3][$];
   logic [127:0] mon_e;
   int           mon_s;
   int           run_len;

   // DUT 0: DATA_W=4 SECDED=1 CNT_W=16 (CODE_W=8)
   wire        a_ir, a_ov;
   wire [7:0]  a_do;
   wire [15:0] a_cnt;
   hamming_secded_enc_stream #(.DATA_W(4), .SECDED(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(a_ir),
      .data_in(din[0][3:0]), .inj_mask(msk[0][7:0]), .out_valid(a_ov),
      .out_ready(out_ready[0]), .data_out(a_do), .word_cnt(a_cnt));

   // DUT 1: DATA_W=11 SECDED=1 CNT_W=4 (CODE_W=16)
   wire        b_ir, b_ov;
   wire [15:0] b_do;
   wire [3:0]  b_cnt;
   hamming_secded_enc_stream #(.DATA_W(11), .SECDED(1), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(b_ir),
      .data_in(din[1][10:0]), .inj_mask(msk[1][15:0]), .out_valid(b_ov),
      .out_ready(out_ready[1]), .data_out(b_do), .word_cnt(b_cnt));

   // DUT 2: DATA_W=26 SECDED=0 CNT_W=16 (CODE_W=31)
   wire        c_ir, c_ov;
   wire [30:0] c_do;
   wire [15:0] c_cnt;
   hamming_secded_enc_stream #(.DATA_W(26), .SECDED(0), .CNT_W(16)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(c_ir),
      .data_in(din[2][25:0]), .inj_mask(msk[2][30:0]), .out_valid(c_ov),
      .out_ready(out_ready[2]), .data_out(c_do), .word_cnt(c_cnt));

   function automatic int dw_of(input int g);
      case (g)
         0: return 4;
         1: return 11;
         default: return 26;
      endcase
   endfunction

   function automatic int sd_of(input int g);
      return (g == 2) ? 0 : 1;
   endfunction

   function automatic int hw_of(input int g);
      int r;
      r = 0;
      while ((1 << r) < dw_of(g) + r + 1) r++;
      return dw_of(g) + r;
   endfunction

   function automatic int cw_of(input int g);
      return hw_of(g) + sd_of(g);
   endfunction

   function automatic logic [127:0] get_dout(input int g);
      case (g)
         0: return {120'd0, a_do};
         1: return {112'd0, b_do};
         default: return {97'd0, c_do};
      endcase
   endfunction

   function automatic logic get_ov(input int g);
      case (g)
         0: return a_ov;
         1: return b_ov;
         default: return c_ov;
      endcase
   endfunction

   function automatic logic get_ir(input int g);
      case (g)
         0: return a_ir;
         1: return b_ir;
         default: return c_ir;
      endcase
   endfunction

   function automatic logic [31:0] get_cnt(input int g);
      case (g)
         0: return {16'd0, a_cnt};
         1: return {28'd0, b_cnt};
         default: return {16'd0, c_cnt};
      endcase
   endfunction

   // XOR of the positions (1-based) of every set bit among the Hamming positions
   function automatic int syndrome(input logic [127:0] v, input int hw);
      int s;
      s = 0;
      for (int p = 1; p <= hw; p++) if (v[p-1]) s = s ^ p;
      return s;
   endfunction

   // Reference: data bits go to the non-power-of-two positions. Parity bit k is
   // bit k of the XOR of the positions that hold a 1, which makes the syndrome 0.
   function automatic logic [127:0] ref_enc(input int g, input logic [127:0] d);
      logic [127:0] code;
      int pos, syn, hw;
      code = 128'd0;
      syn  = 0;
      pos  = 1;
      hw   = hw_of(g);
      for (int j = 0; j < dw_of(g); j++) begin
         while ((pos & (pos - 1)) == 0) pos++;
         code[pos-1] = d[j];
         if (d[j]) syn = syn ^ pos;
         pos++;
      end
      for (int k = 0; (1 << k) <= hw; k++) code[(1 << k) - 1] = syn[k];
      if (sd_of(g) != 0) code[hw] = ^code;
      return code;
   endfunction

   function automatic logic [127:0] rnd_bits(input int w);
      logic [127:0] v;
      logic [127:0] one;
      one = 128'd1;
      v = {$urandom, $urandom, $urandom, $urandom};
      return v & ((one << w) - 128'd1);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Present one word on DUT g and hold it until it is accepted (bounded)
   task automatic send(input int g, input logic [127:0] d, input logic [127:0] m);
      int t;
      t = 0;
      in_valid[g] = 1'b1;
      din[g]      = d;
      msk[g]      = m;
      @(negedge clk);
      while (!get_ir(g) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout dut%0d: in_ready stayed %0b, required 1", g, get_ir(g));
      end
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
   endtask

   // out_ready driver
   initial begin
      for (int g = 0; g < 3; g++) out_ready[g] = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         for (int g = 0; g < 3; g++)
            out_ready[g] = (mode[g] == 0) ? 1'b0 :
                           (mode[g] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard: push on accept, pop and compare on each output handshake
   always @(negedge clk) begin
      if (rst) begin
         for (int g = 0; g < 3; g++) begin
            sbq[g].delete();
            synq[g].delete();
         end
      end else begin
         for (int g = 0; g < 3; g++) begin
            if (get_ov(g) && out_ready[g]) begin
               checks++;
               if (sbq[g].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_word dut%0d: got %0h, required no word", g, get_dout(g));
               end else begin
                  mon_e = sbq[g].pop_front();
                  mon_s = synq[g].pop_front();
                  if (get_dout(g) !== mon_e) begin
                     errors++;
                     $display("FAIL codeword dut%0d: got %0h, required %0h", g, get_dout(g), mon_e);
                  end
                  checks++;
                  if (syndrome(get_dout(g), hw_of(g)) != mon_s) begin
                     errors++;
                     $display("FAIL syndrome dut%0d: got %0d, required %0d", g,
                              syndrome(get_dout(g), hw_of(g)), mon_s);
                  end
               end
            end
            if (in_valid[g] && get_ir(g)) begin
               sbq[g].push_back(ref_enc(g, din[g]) ^ msk[g]);
               synq[g].push_back(syndrome(msk[g], hw_of(g)));
            end
         end
      end
   end

   initial begin
      int t;
      for (int g = 0; g < 3; g++) begin
         in_valid[g] = 1'b0;
         din[g]      = 128'd0;
         msk[g]      = 128'd0;
         mode[g]     = 1;
      end
      // Reset state
      #1 rst = 1'b1;
      #2;
      for (int g = 0; g < 3; g++) begin
         chk("rst_out_valid", get_ov(g), 128'd0);
         chk("rst_data_out", get_dout(g), 128'd0);
         chk("rst_word_cnt", get_cnt(g), 128'd0);
         chk("rst_in_ready", get_ir(g), 128'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("in_ready_after_rst", get_ir(0), 128'd1);

      // Directed DATA_W=4 codewords, one cycle after accept
      @(posedge clk); #1;
      send(0, 128'h0, 128'h0); chk("enc_0", get_dout(0), 128'h00); chk("lat_0", get_ov(0), 128'd1);
      send(0, 128'h1, 128'h0); chk("enc_1", get_dout(0), 128'h87);
      send(0, 128'hB, 128'h0); chk("enc_B", get_dout(0), 128'h55);
      send(0, 128'hF, 128'h0); chk("enc_F", get_dout(0), 128'hFF);

      // Injection
      send(0, 128'hB, 128'h04); chk("inj_04", get_dout(0), 128'h51);
      send(0, 128'hB, 128'h80); chk("inj_80", get_dout(0), 128'hD5);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: three words offered, two taken, output held
      mode[0] = 0; in_valid[0] = 1'b1; din[0] = 128'h3; msk[0] = 128'd0;
      @(posedge clk); #1; din[0] = 128'hA;
      @(posedge clk); #1; din[0] = 128'h6;
      @(posedge clk); #1;
      chk("bp_in_ready_low", get_ir(0), 128'd0);
      chk("bp_out_valid", get_ov(0), 128'd1);
      chk("bp_first_word", get_dout(0), ref_enc(0, 128'h3));
      repeat (2) @(posedge clk);
      #1 chk("bp_held", get_dout(0), ref_enc(0, 128'h3));
      mode[0] = 1;
      @(posedge clk); #1;
      chk("bp_in_ready_back", get_ir(0), 128'd1);
      chk("bp_second_word", get_dout(0), ref_enc(0, 128'hA));
      @(posedge clk); #1; in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("bp_all_drained", 128'(sbq[0].size()), 128'd0);

      // Throughput and counter wrap, fresh counters
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      run_len = 0;
      fork
         for (int i = 0; i < 100; i++) send(0, rnd_bits(4), 128'd0);
         for (int i = 0; i < 100; i++) send(1, rnd_bits(11), 128'd0);
         begin
            int w;
            w = 0;
            while (!get_ov(0) && w < 50) begin @(negedge clk); w++; end
            while (get_ov(0) && run_len < 300) begin run_len++; @(negedge clk); end
         end
      join
      repeat (3) @(posedge clk);
      #1;
      chk("throughput_run", 128'(run_len), 128'd100);
      chk("word_cnt_100", get_cnt(0), 128'd100);
      chk("word_cnt_wrap4", get_cnt(1), 128'd4);

      // Reset mid-stream with skid full
      mode[0] = 0;
      send(0, 128'h5, 128'd0);
      send(0, 128'h9, 128'd0);
      chk("skid_full", get_ir(0), 128'd0);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", get_ov(0), 128'd0);
      chk("midrst_word_cnt", get_cnt(0), 128'd0);
      chk("midrst_data_out", get_dout(0), 128'd0);
      chk("midrst_in_ready", get_ir(0), 128'd0);
      @(posedge clk); #1 rst = 1'b0;
      #1 chk("postrst_in_ready", get_ir(0), 128'd1);
      mode[0] = 1;
      send(0, 128'hB, 128'd0);
      chk("postrst_enc_B", get_dout(0), 128'h55);

      // Wide configurations: random data, masks and backpressure
      mode[1] = 2; mode[2] = 2;
      fork
         for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            send(1, rnd_bits(11), (sel == 0) ? rnd_bits(16) :
                 (sel == 1) ? (128'd1 << $urandom_range(0, 15)) : 128'd0);
         end
         for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            send(2, rnd_bits(26), (sel == 0) ? rnd_bits(31) :
                 (sel == 1) ? (128'd1 << $urandom_range(0, 30)) : 128'd0);
         end
      join
      // Every single-bit mask over the Hamming positions
      fork
         for (int i = 1; i <= 15; i++) send(1, rnd_bits(11), 128'd1 << (i - 1));
         for (int i = 1; i <= 31; i++) send(2, rnd_bits(26), 128'd1 << (i - 1));
      join

      mode[1] = 1; mode[2] = 1;
      t = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1 chk("final_drain", 128'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
